// File: rtl/rst_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq_gen
// Purpose  : Reset source: holds all active-low outputs low, then staggers release.
// Revision : 1.0
// ============================================================================
module rst_seq_gen #(
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4,
    parameter int NUM_OUTS       = 3
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                SW_RST_REQ,
    output logic [NUM_OUTS-1:0] RST_OUT_N,
    output logic                BUSY,
    output logic                DONE
);

    localparam int c_MAX_HS = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int c_MAX    = (c_MAX_HS > NUM_OUTS) ? c_MAX_HS : NUM_OUTS;
    localparam int c_CNT_W  = $clog2(c_MAX) + 1;

    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_STAG_LAST = c_CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_IDX_LAST  = c_CNT_W'(NUM_OUTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                r_state,    w_state_nxt;
    logic [c_CNT_W-1:0]    r_hold_cnt, w_hold_nxt;
    logic [c_CNT_W-1:0]    r_stag_cnt, w_stag_nxt;
    logic [c_CNT_W-1:0]    r_idx,      w_idx_nxt;
    logic [NUM_OUTS-1:0]   r_out_n,    w_out_nxt;
    logic                  r_busy,     w_busy_nxt;
    logic                  r_done,     w_done_nxt;
    logic                  r_req_prev;
    logic                  w_trigger;

    // req_prev resets high so a request held through reset is not seen as an edge
    assign w_trigger = SW_RST_REQ & ~r_req_prev;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= ST_ASSERT;
            r_hold_cnt <= '0;
            r_stag_cnt <= '0;
            r_idx      <= '0;
            r_out_n    <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_req_prev <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_stag_cnt <= w_stag_nxt;
            r_idx      <= w_idx_nxt;
            r_out_n    <= w_out_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_req_prev <= SW_RST_REQ;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_stag_nxt  = r_stag_cnt;
        w_idx_nxt   = r_idx;
        w_out_nxt   = r_out_n;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        // A trigger outranks any release or DONE due on the same edge
        if (w_trigger) begin
            w_state_nxt = ST_ASSERT;
            w_hold_nxt  = '0;
            w_stag_nxt  = '0;
            w_idx_nxt   = '0;
            w_out_nxt   = '0;
            w_busy_nxt  = 1'b1;
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    w_out_nxt = '0;
                    if (r_hold_cnt == c_HOLD_LAST) begin
                        w_stag_nxt = '0;
                        if (NUM_OUTS == 1) begin
                            w_state_nxt = ST_IDLE;
                            w_out_nxt   = '1;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt  = ST_RELEASE;
                            w_out_nxt[0] = 1'b1;
                            w_idx_nxt    = c_CNT_W'(1);
                        end
                    end else begin
                        w_hold_nxt = r_hold_cnt + c_CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (r_stag_cnt == c_STAG_LAST) begin
                        w_stag_nxt = '0;
                        for (int i = 0; i < NUM_OUTS; i++) begin
                            if (r_idx == c_CNT_W'(i)) begin
                                w_out_nxt[i] = 1'b1;
                            end
                        end
                        if (r_idx == c_IDX_LAST) begin
                            w_state_nxt = ST_IDLE;
                            w_out_nxt   = '1;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + c_CNT_W'(1);
                        end
                    end else begin
                        w_stag_nxt = r_stag_cnt + c_CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    w_out_nxt  = '1;
                    w_busy_nxt = 1'b0;
                end
                default: begin
                    // Unreachable encoding: fall back into a fresh reset hold
                    w_state_nxt = ST_ASSERT;
                    w_hold_nxt  = '0;
                    w_out_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                end
            endcase
        end
    end

    assign RST_OUT_N = r_out_n;
    assign BUSY      = r_busy;
    assign DONE      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_rst_seq_gen
// Purpose  : Directed scoreboard bench for rst_seq_gen release schedule.
// Revision : 1.0
// ============================================================================
module tb_rst_seq_gen;

    localparam int H = 16;
    localparam int S = 4;
    localparam int N = 3;

    logic         CLK;
    logic         RST;
    logic         SW_RST_REQ;
    logic [N-1:0] RST_OUT_N;
    logic         BUSY;
    logic         DONE;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string        tag;
        int           e;
        logic [N-1:0] out;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t sb[$];

    rst_seq_gen #(
        .HOLD_CYCLES    (H),
        .STAGGER_CYCLES (S),
        .NUM_OUTS       (N)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .SW_RST_REQ (SW_RST_REQ),
        .RST_OUT_N  (RST_OUT_N),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Expected state just after relative edge e of a sequence
    function automatic exp_t mk(input string tag, input int e);
        exp_t x;
        x.tag = tag;
        x.e   = e;
        for (int k = 0; k < N; k++) x.out[k] = (e >= H + k * S);
        x.busy = (e < H + (N - 1) * S);
        x.done = (e == H + (N - 1) * S);
        return x;
    endfunction

    task automatic push_window(input string tag, input int from, input int to);
        for (int e = from; e <= to; e++) sb.push_back(mk(tag, e));
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_next();
        exp_t x;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=empty expected=entry");
        end else begin
            x = sb.pop_front();
            assert (RST_OUT_N === x.out) else begin
                failures++;
                $error("FAIL %s e=%0d RST_OUT_N observed=%b expected=%b", x.tag, x.e, RST_OUT_N, x.out);
            end
            checks++;
            assert (BUSY === x.busy) else begin
                failures++;
                $error("FAIL %s e=%0d BUSY observed=%b expected=%b", x.tag, x.e, BUSY, x.busy);
            end
            checks++;
            assert (DONE === x.done) else begin
                failures++;
                $error("FAIL %s e=%0d DONE observed=%b expected=%b", x.tag, x.e, DONE, x.done);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check_next();
        end
    endtask

    initial begin
        RST        = 1'b0;
        SW_RST_REQ = 1'b0;

        // Power-on: 5 cycles in reset, then edges 1..30
        push_window("por_rst", 0, 0);
        push_window("por_rst", 0, 0);
        push_window("por_rst", 0, 0);
        push_window("por_rst", 0, 0);
        push_window("por_rst", 0, 0);
        push_window("por", 1, 30);
        run(5);
        RST = 1'b1;
        run(30);

        // Single software pulse from IDLE
        push_window("sw_pulse", 0, 30);
        SW_RST_REQ = 1'b1;
        tick();
        check_next();
        SW_RST_REQ = 1'b0;
        run(30);

        // Second pulse 10 edges into ASSERT restarts the hold
        push_window("extend_a", 0, 9);
        push_window("extend_b", 0, 30);
        SW_RST_REQ = 1'b1;
        tick();
        check_next();
        SW_RST_REQ = 1'b0;
        run(9);
        SW_RST_REQ = 1'b1;
        tick();
        check_next();
        SW_RST_REQ = 1'b0;
        run(30);

        // Pulse one edge after bit 0 released aborts the sequence
        push_window("abort_a", 0, 16);
        push_window("abort_b", 0, 30);
        SW_RST_REQ = 1'b1;
        tick();
        check_next();
        SW_RST_REQ = 1'b0;
        run(16);
        SW_RST_REQ = 1'b1;
        tick();
        check_next();
        SW_RST_REQ = 1'b0;
        run(30);

        // Request held high through reset: only the power-on sequence runs
        push_window("held_rst", 0, 0);
        push_window("held_rst", 0, 0);
        push_window("held_rst", 0, 0);
        push_window("held_por", 1, 36);
        push_window("held_retrig", 0, 30);
        SW_RST_REQ = 1'b1;
        RST        = 1'b0;
        run(3);
        RST = 1'b1;
        run(35);
        SW_RST_REQ = 1'b0;
        run(1);
        SW_RST_REQ = 1'b1;
        tick();
        check_next();
        SW_RST_REQ = 1'b0;
        run(30);

        // Asynchronous reset between edges while outputs read 011
        push_window("async_pre", 0, 21);
        push_window("async_now", 0, 0);
        push_window("async_rst", 0, 0);
        push_window("async_rst", 0, 0);
        push_window("async_por", 1, 30);
        SW_RST_REQ = 1'b1;
        tick();
        check_next();
        SW_RST_REQ = 1'b0;
        run(21);
        #2;
        RST = 1'b0;
        #1;
        check_next();
        run(2);
        RST = 1'b1;
        run(30);

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rst_seq_gen.md
# rst_seq_gen

Reset sequence generator: the source end of the design's reset distribution. It produces registered, active-low reset outputs, one per downstream reset domain, and each downstream domain re-synchronizes its output locally.
- A power-on reset or a synchronous software reset request asserts all outputs together.
- The block holds them asserted for a guaranteed minimum width.
- It then releases them one at a time in a fixed, staggered order, so domains come out of reset in a defined sequence.

## Interface
- HOLD_CYCLES, 16, minimum number of CLK cycles all outputs stay asserted after the trigger; must be ≥ 1.
- STAGGER_CYCLES, 4, CLK cycles between successive output releases; must be ≥ 1.
- NUM_OUTS, 3, number of reset outputs; must be ≥ 1.
- CLK  input  1  block clock.
- RST  input  1  reset, asynchronous, active-low.
- SW_RST_REQ  input  1  software reset request, synchronous to CLK; a rising edge triggers a sequence.
- RST_OUT_N  output  NUM_OUTS  reset outputs, active-low, registered; bit 0 releases first.
- BUSY  output  1  high while any output is asserted (states ASSERT or RELEASE).
- DONE  output  1  one-cycle pulse when the last output releases.

## Operation
- RST low: asynchronously set RST_OUT_N = all 0, BUSY = 1, DONE = 0, state = ASSERT, counters = 0, req_prev = 1.
- Edge detect: trigger = SW_RST_REQ & ~req_prev; req_prev is registered every cycle.
  - Because req_prev resets to 1, a request held high through reset does not retrigger.
- States:
  - ASSERT:
    - All outputs 0; hold counter increments each edge.
    - On the edge where hold counter == HOLD_CYCLES-1: set RST_OUT_N[0] = 1, load idx = 1, clear the stagger counter, go to RELEASE.
    - If NUM_OUTS == 1, go directly to IDLE on that edge with DONE = 1.
  - RELEASE:
    - Stagger counter increments each edge.
    - On the edge where stagger counter == STAGGER_CYCLES-1: set RST_OUT_N[idx] = 1 and clear the stagger counter.
    - If idx == NUM_OUTS-1: go to IDLE and drive DONE = 1 for that cycle only. Otherwise idx increments.
  - IDLE: all outputs 1, BUSY = 0; wait for trigger.
- Trigger in any state:
  - Next edge: RST_OUT_N = all 0, hold counter = 0, state = ASSERT, DONE = 0.
  - In ASSERT, a trigger restarts the hold, extending the reset.
  - In RELEASE, a trigger re-asserts any outputs already released and aborts the sequence; no DONE is produced.
- Trigger has priority over a release or DONE scheduled for the same edge.
- Counter widths: $clog2 of the max of HOLD_CYCLES, STAGGER_CYCLES and NUM_OUTS, plus 1. Counters never wrap.
- All outputs come directly from flops; there is no combinational path from inputs to outputs.

## Timing
- Edge numbering:
  - Edge 0 is the trigger edge: the first CLK edge with RST high, or the edge sampling trigger = 1.
  - Edges are counted after that.
- Release schedule:
  - RST_OUT_N[k] rises at edge HOLD_CYCLES + k·STAGGER_CYCLES.
  - For a power-on sequence, edge numbering starts at the first edge after RST deasserts, so edge 1 is the first edge with RST high.
- DONE is high for exactly the cycle following edge HOLD_CYCLES + (NUM_OUTS-1)·STAGGER_CYCLES.
- BUSY falls on that same edge.
- Software trigger latency: outputs go low 1 edge after SW_RST_REQ is sampled high.
- RST asserted mid-sequence: outputs go to 0 immediately (asynchronous, no CLK edge needed), and the sequence restarts when RST deasserts.
- Minimum asserted width of every output is HOLD_CYCLES cycles, regardless of trigger pattern.

## Test plan
- Defaults (HOLD_CYCLES = 16, STAGGER_CYCLES = 4, NUM_OUTS = 3), RST low for 5 cycles then released -> RST_OUT_N = 000 during reset; bits 0, 1, 2 rise at edges 16, 20, 24; DONE = 1 only after edge 24; BUSY falls at edge 24.
- IDLE, 1-cycle SW_RST_REQ pulse sampled at edge r -> RST_OUT_N = 000 after r+1; releases at r+16, r+20, r+24; exactly one DONE pulse.
- Second request pulse 10 edges into ASSERT -> hold restarts; RST_OUT_N[0] rises 16 edges after the second request, not the first.
- Request one edge after RST_OUT_N[0] has risen (RELEASE) -> RST_OUT_N returns to 000 on the next edge; full 16/20/24 schedule restarts; no DONE from the aborted sequence.
- SW_RST_REQ held high through RST and beyond -> exactly one (power-on) sequence; no retrigger until SW_RST_REQ goes low and then high again.
- RST driven low asynchronously between edges while RST_OUT_N = 011 -> RST_OUT_N = 000 and DONE = 0 before the next CLK edge; a fresh sequence follows RST release.
